// File: rtl/image_bram_arbiter_pkg.sv
// Frame geometry, bus widths and enums shared by the image BRAM arbiter.
// Latency/backpressure: not applicable, types and constants only.
package image_bram_arbiter_pkg;

    localparam int WIDTH      = 1280;
    localparam int HEIGHT     = 720;
    localparam int IMAGE_SIZE = WIDTH * HEIGHT;
    localparam int ADDR_WIDTH = $clog2(IMAGE_SIZE);
    localparam int DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHARE = 2'd1,
        DRAIN = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        REQ_WR  = 2'd0,
        REQ_RD0 = 2'd1,
        REQ_RD1 = 2'd2
    } req_id_t;

endpackage

// File: rtl/image_bram_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser.
// Latency 0; grants nothing while en is low, and the pointer holds.
module rr_arbiter2 (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic ptr;  // 0 favours req0, 1 favours req1

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = ~ptr;
                gnt1 = ptr;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/image_bram_arbiter.sv
// Shares the single-port frame BRAM between one writer and two readers across LOAD/SHARE/DRAIN.
// Grants are same-cycle; read data returns one cycle after grant; requesters hold until granted.
module image_bram_arbiter #(
    parameter int IMAGE_SIZE = image_bram_arbiter_pkg::IMAGE_SIZE,
    parameter int ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int DATA_WIDTH = image_bram_arbiter_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_finished,
    input  logic                  frame_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd0_req,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_gnt,
    output logic                  rd0_valid,
    output logic [DATA_WIDTH-1:0] rd0_data,
    input  logic                  rd1_req,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_gnt,
    output logic                  rd1_valid,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [1:0]            phase,
    output logic [15:0]           frame_count
);

    import image_bram_arbiter_pkg::*;

    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(IMAGE_SIZE);

    phase_t                state, state_nxt;
    logic [15:0]           frame_cnt;
    logic                  rd_arb_en;
    logic                  any_gnt;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  tag_vld;
    req_id_t               tag_id;
    logic                  tag_oob;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN lingers exactly one extra cycle when the frame_done-cycle read is still returning.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (load_finished) state_nxt = SHARE;
            SHARE:   if (frame_done)    state_nxt = DRAIN;
            DRAIN:   if (!tag_vld)      state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (state == DRAIN && state_nxt == LOAD) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    rr_arbiter2 u_rd_arb (
        .clock (clock),
        .reset (reset),
        .en    (rd_arb_en),
        .req0  (rd0_req),
        .req1  (rd1_req),
        .gnt0  (rd0_gnt),
        .gnt1  (rd1_gnt)
    );

    // Writer outranks both readers; nothing is granted while reset is held.
    always_comb begin
        wr_gnt    = 1'b0;
        rd_arb_en = 1'b0;
        if (!reset) begin
            wr_gnt    = wr_req && (state == LOAD || state == SHARE);
            rd_arb_en = (state == SHARE) && !wr_req;
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        if (wr_gnt) begin
            sel_addr  = wr_addr;
            sel_wdata = wr_data;
        end else if (rd0_gnt) begin
            sel_addr  = rd0_addr;
        end else if (rd1_gnt) begin
            sel_addr  = rd1_addr;
        end
    end

    assign any_gnt    = wr_gnt | rd0_gnt | rd1_gnt;
    assign in_range   = {1'b0, sel_addr} < ADDR_LIMIT;
    assign bram_en    = any_gnt & in_range;
    assign bram_we    = wr_gnt & in_range;
    assign bram_addr  = sel_addr;
    assign bram_wdata = sel_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_vld <= 1'b0;
            tag_id  <= REQ_RD0;
            tag_oob <= 1'b0;
        end else begin
            tag_vld <= rd0_gnt | rd1_gnt;
            tag_id  <= rd1_gnt ? REQ_RD1 : REQ_RD0;
            tag_oob <= ~in_range;
        end
    end

    assign rd0_valid   = tag_vld && (tag_id == REQ_RD0);
    assign rd1_valid   = tag_vld && (tag_id == REQ_RD1);
    assign rd0_data    = (rd0_valid && !tag_oob) ? bram_rdata : '0;
    assign rd1_data    = (rd1_valid && !tag_oob) ? bram_rdata : '0;
    assign phase       = state;
    assign frame_count = frame_cnt;

endmodule

// File: tb/tb_image_bram_arbiter.sv
// Directed bench for image_bram_arbiter: grant/bus checks inline, read returns via scoreboard.
module tb_image_bram_arbiter;

    localparam int AW = image_bram_arbiter_pkg::ADDR_WIDTH;
    localparam int DW = image_bram_arbiter_pkg::DATA_WIDTH;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_finished, frame_done;
    logic          wr_req, rd0_req, rd1_req;
    logic [AW-1:0] wr_addr, rd0_addr, rd1_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
    logic [DW-1:0] rd0_data, rd1_data;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata = 24'h5A5A5A;
    logic [1:0]    phase;
    logic [15:0]   frame_count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    image_bram_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .load_finished (load_finished),
        .frame_done    (frame_done),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_gnt        (wr_gnt),
        .rd0_req       (rd0_req),
        .rd0_addr      (rd0_addr),
        .rd0_gnt       (rd0_gnt),
        .rd0_valid     (rd0_valid),
        .rd0_data      (rd0_data),
        .rd1_req       (rd1_req),
        .rd1_addr      (rd1_addr),
        .rd1_gnt       (rd1_gnt),
        .rd1_valid     (rd1_valid),
        .rd1_data      (rd1_data),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata),
        .phase         (phase),
        .frame_count   (frame_count)
    );

    // BRAM model: registered read, word content is a tag plus its own address.
    always @(posedge clock) begin
        if (bram_en && !bram_we) bram_rdata <= {4'hA, bram_addr};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus(input string name, input logic wg, input logic r0, input logic r1,
                       input logic en, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk(name, 64'({wr_gnt, rd0_gnt, rd1_gnt, bram_en, bram_we, bram_addr, bram_wdata}),
                  64'({wg, r0, r1, en, we, a, d}));
    endtask

    task automatic exp_rd(input logic id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Monitor: every read return must match the oldest expected entry, the other lane stays 0.
    always @(negedge clock) begin
        if (rd0_valid || rd1_valid) begin
            vectors++;
            if (rd0_valid && rd1_valid) begin
                miscompares++;
                $display("FAIL rd_return_both: got both valids expected one");
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_return_unexpected: got valid on rd%0d expected none", rd1_valid);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.id !== rd1_valid
                    || (rd1_valid ? rd1_data : rd0_data) !== e.data
                    || (rd1_valid ? rd0_data : rd1_data) !== '0) begin
                    miscompares++;
                    $display("FAIL rd_return: got rd%0d data %0h other %0h expected rd%0d data %0h other 0",
                             rd1_valid, rd1_valid ? rd1_data : rd0_data,
                             rd1_valid ? rd0_data : rd1_data, e.id, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        load_finished = 1'b0; frame_done = 1'b0;
        rd0_req = 1'b0; rd1_req = 1'b0; rd0_addr = '0; rd1_addr = '0;
        wr_req = 1'b1; wr_addr = 20'd5; wr_data = 24'h111111;
        repeat (2) @(negedge clock);
        bus("reset_bus", 0, 0, 0, 0, 0, '0, '0);
        chk("reset_phase", 64'(phase), 64'd0);
        chk("reset_fcount", 64'(frame_count), 64'd0);
        chk("reset_valid", 64'({rd0_valid, rd1_valid}), 64'd0);

        // LOAD: writer exclusive even with both readers asking
        step; reset = 1'b0;
        rd0_req = 1'b1; rd1_req = 1'b1; rd0_addr = 20'd7; rd1_addr = 20'd8;
        for (int i = 0; i < 10; i++) begin
            wr_req = 1'b1; wr_addr = 20'(i); wr_data = {4'h5, 20'(i)};
            @(negedge clock);
            bus("load_wr", 1, 0, 0, 1, 1, 20'(i), {4'h5, 20'(i)});
            step;
        end
        wr_addr = 20'd10; wr_data = 24'h50000A; load_finished = 1'b1;
        @(negedge clock);
        bus("load_finished_wr", 1, 0, 0, 1, 1, 20'd10, 24'h50000A);
        chk("load_finished_phase", 64'(phase), 64'd0);
        step;
        load_finished = 1'b1; wr_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
        @(negedge clock);
        chk("share_entry", 64'(phase), 64'd1);
        bus("share_idle", 0, 0, 0, 0, 0, '0, '0);
        step;
        load_finished = 1'b0;
        @(negedge clock);
        chk("load_finished_ignored", 64'(phase), 64'd1);

        // SHARE round-robin with both readers held
        for (int k = 0; k < 6; k++) begin
            step;
            rd0_req = 1'b1; rd1_req = 1'b1;
            rd0_addr = 20'(100 + k); rd1_addr = 20'(200 + k);
            @(negedge clock);
            if (k % 2 == 0) begin
                bus("rr_rd0", 0, 1, 0, 1, 0, 20'(100 + k), '0);
                exp_rd(1'b0, {4'hA, 20'(100 + k)});
            end else begin
                bus("rr_rd1", 0, 0, 1, 1, 0, 20'(200 + k), '0);
                exp_rd(1'b1, {4'hA, 20'(200 + k)});
            end
        end

        // Write priority, then pointer behaviour with single and dual requesters
        step;
        wr_req = 1'b1; wr_addr = 20'd50; wr_data = 24'h123456;
        rd0_addr = 20'd300; rd1_addr = 20'd301;
        @(negedge clock);
        bus("wr_priority", 1, 0, 0, 1, 1, 20'd50, 24'h123456);
        step;
        wr_req = 1'b0;
        @(negedge clock);
        bus("after_wr_rd0", 0, 1, 0, 1, 0, 20'd300, '0);
        exp_rd(1'b0, {4'hA, 20'd300});
        step;
        rd1_req = 1'b0; rd0_addr = 20'd302;
        @(negedge clock);
        bus("single_rd0", 0, 1, 0, 1, 0, 20'd302, '0);
        exp_rd(1'b0, {4'hA, 20'd302});
        step;
        rd1_req = 1'b1; rd0_addr = 20'd303;
        @(negedge clock);
        bus("ptr_to_rd1", 0, 0, 1, 1, 0, 20'd301, '0);
        exp_rd(1'b1, {4'hA, 20'd301});

        // Address boundary
        step;
        rd0_req = 1'b0; rd1_addr = 20'd921600;
        @(negedge clock);
        bus("oob_rd1", 0, 0, 1, 0, 0, 20'd921600, '0);
        exp_rd(1'b1, '0);
        step;
        rd1_addr = 20'd921599;
        @(negedge clock);
        bus("last_rd1", 0, 0, 1, 1, 0, 20'd921599, '0);
        exp_rd(1'b1, {4'hA, 20'd921599});
        step;
        rd1_req = 1'b0; wr_req = 1'b1; wr_addr = 20'd921600; wr_data = 24'hABCDEF;
        @(negedge clock);
        bus("oob_wr", 1, 0, 0, 0, 0, 20'd921600, 24'hABCDEF);
        step;
        wr_req = 1'b0; rd0_req = 1'b1; rd0_addr = 20'hFFFFF;
        @(negedge clock);
        bus("oob_rd0_max", 0, 1, 0, 0, 0, 20'hFFFFF, '0);
        exp_rd(1'b0, '0);

        // frame_done with a read granted in the same cycle: DRAIN for two cycles
        step;
        rd0_addr = 20'd400; frame_done = 1'b1;
        @(negedge clock);
        bus("frame_done_rd0", 0, 1, 0, 1, 0, 20'd400, '0);
        exp_rd(1'b0, {4'hA, 20'd400});
        step;
        frame_done = 1'b0; rd0_addr = 20'd401; rd1_req = 1'b1;
        wr_req = 1'b1; wr_addr = 20'd1; wr_data = 24'h000007;
        @(negedge clock);
        chk("drain_phase1", 64'(phase), 64'd2);
        bus("drain_no_gnt1", 0, 0, 0, 0, 0, '0, '0);
        step;
        @(negedge clock);
        chk("drain_phase2", 64'(phase), 64'd2);
        chk("drain_fcount", 64'(frame_count), 64'd0);
        bus("drain_no_gnt2", 0, 0, 0, 0, 0, '0, '0);
        step;
        rd0_req = 1'b0; rd1_req = 1'b0; frame_done = 1'b1;
        @(negedge clock);
        chk("reload_phase", 64'(phase), 64'd0);
        chk("fcount_1", 64'(frame_count), 64'd1);
        bus("reload_wr", 1, 0, 0, 1, 1, 20'd1, 24'h000007);
        step;
        frame_done = 1'b0; wr_req = 1'b0;
        @(negedge clock);
        chk("frame_done_ignored", 64'(phase), 64'd0);

        // Second frame with nothing in flight: DRAIN lasts one cycle
        step; load_finished = 1'b1;
        step; load_finished = 1'b0; frame_done = 1'b1;
        @(negedge clock);
        chk("f2_share", 64'(phase), 64'd1);
        step; frame_done = 1'b0;
        @(negedge clock);
        chk("f2_drain", 64'(phase), 64'd2);
        step;
        @(negedge clock);
        chk("f2_load", 64'(phase), 64'd0);
        chk("fcount_2", 64'(frame_count), 64'd2);

        // Reset while a read is in flight
        step; load_finished = 1'b1;
        step; load_finished = 1'b0; rd0_req = 1'b1; rd0_addr = 20'd500;
        @(negedge clock);
        bus("pre_reset_rd0", 0, 1, 0, 1, 0, 20'd500, '0);
        step; reset = 1'b1; rd0_req = 1'b0;
        @(negedge clock);
        chk("reset_mid_valid", 64'({rd0_valid, rd1_valid}), 64'd0);
        step; reset = 1'b0;
        @(negedge clock);
        chk("post_reset_valid", 64'({rd0_valid, rd1_valid}), 64'd0);
        chk("post_reset_phase", 64'(phase), 64'd0);
        chk("post_reset_fcount", 64'(frame_count), 64'd0);
        repeat (2) @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/image_bram_arbiter.md
Name: image_bram_arbiter

Overview:
- Owns the single-port full-frame image BRAM and shares it between one write requester and two read requesters.
- The write requester is the image loader, or the lane overlay writer after loading.
- Read requester 0 is the lane highlighter. Read requester 1 is the final output streamer.
- Sequences each frame through three phases: load (writer exclusive), share (all requesters arbitrated), drain (flush in-flight reads). The loader cannot overwrite a frame the back end is still reading.

Parameters:
- IMAGE_SIZE, 921600: pixels per frame (WIDTH*HEIGHT from globals).
- ADDR_WIDTH, $clog2(IMAGE_SIZE): BRAM address width.
- DATA_WIDTH, 24: RGB pixel width.

Ports:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- load_finished  in  1  one-cycle pulse from loader after last pixel written
- frame_done  in  1  one-cycle pulse from output streamer after last pixel consumed
- wr_req  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_gnt  out  1  write accepted this cycle
- rd0_req / rd1_req  in  1  read requests
- rd0_addr / rd1_addr  in  ADDR_WIDTH  read addresses
- rd0_gnt / rd1_gnt  out  1  read accepted this cycle
- rd0_valid / rd1_valid  out  1  read data valid (one cycle after grant)
- rd0_data / rd1_data  out  DATA_WIDTH  read data
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_wdata  out  DATA_WIDTH  BRAM write data
- bram_rdata  in  DATA_WIDTH  BRAM read data (registered, 1-cycle latency)
- phase  out  2  current phase (LOAD=0, SHARE=1, DRAIN=2)
- frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
Reset:
- State LOAD. Round-robin pointer favours rd0. frame_count=0. Read pipeline valid bit cleared.
- All outputs 0 except phase=LOAD.
- Reset mid-frame drops any in-flight read; no rdX_valid appears after reset release.

Grants (combinational from current inputs and state):
- At most one grant per cycle.
- LOAD:
  - wr_gnt=wr_req; rd0_gnt=rd1_gnt=0.
  - load_finished -> SHARE next cycle. A write in the same cycle as load_finished is still granted.
- SHARE:
  - Write has fixed highest priority: wr_req -> wr_gnt=1, no read granted that cycle.
  - Otherwise readers are round-robin. If both request, grant the one the pointer favours, then flip the pointer to the other.
  - If only one reader requests, grant it and set the pointer to the other.
  - No request: pointer unchanged.
  - frame_done -> DRAIN next cycle. Grants in the frame_done cycle are still issued.
- DRAIN:
  - No grants.
  - Stay one cycle if a read is in flight; otherwise go to LOAD next cycle. At most 2 cycles in DRAIN.
  - frame_count increments on the DRAIN->LOAD transition.
- load_finished outside LOAD, and frame_done outside SHARE, are ignored.

BRAM drive:
- bram_en = any grant.
- bram_we = wr_gnt.
- bram_addr / bram_wdata: from the granted requester.
- Idle: address and data driven 0.

Out-of-range accesses (addr >= IMAGE_SIZE):
- Still granted (requester never stalls), but bram_en=0.
- Write is discarded.
- Read returns data 0 with valid on the normal schedule.

Read return:
- Registered tag (valid, requester id, oob flag) captured on grant.
- Next cycle, the tagged requester's rdX_valid=1 and rdX_data=bram_rdata (0 if oob). The other requester's data=0.
- Back-to-back grants give back-to-back valids.

Requester contract:
- A requester holds req/addr/data until it sees gnt.
- The arbiter never grants a deasserted request.

Decomposition:
- Shared package (globals): IMAGE_SIZE, WIDTH, HEIGHT, ADDR_WIDTH, DATA_WIDTH, phase_t enum {LOAD, SHARE, DRAIN}, requester id enum {REQ_WR, REQ_RD0, REQ_RD1}.
- One sub-module: rr_arbiter2 (two-way round-robin with a pointer flop), instantiated for the reader pair.
- Phase FSM, priority mux and read-return pipeline stay in the top.

Test Plan:
- LOAD exclusivity: reset, wr_req with addr 0..9 plus rd0_req/rd1_req held high -> wr_gnt every cycle, rd gnts 0, bram_we=1, addresses 0..9.
- Phase sequencing: load_finished pulse at cycle 20 -> phase=SHARE at 21. frame_done at 40 with no reads in flight -> DRAIN at 41, LOAD at 42, frame_count=1.
- Round-robin: in SHARE, rd0/rd1 requests held for 6 cycles -> grants rd0,rd1,rd0,rd1,rd0,rd1. Each rdX_valid one cycle after its grant with bram_rdata echoed.
- Write priority: in SHARE, wr_req and both reads together -> wr_gnt only. Next cycle without wr_req -> the pointer-favoured reader is granted.
- Boundary: read addr 921600 -> granted, bram_en=0, rd valid next cycle with data 0. Write addr 921600 -> wr_gnt=1, bram_we=0.
- Reset mid-read: read granted at cycle N, reset asserted at N+1 -> no rdX_valid. After release, phase=LOAD, frame_count=0.
